jtdd_mcu_comm: RTL and testbench

- Communication block between the main CPU and the 63701 MCU.
- Holds a 512x8 shared RAM. Either the MCU or the main CPU owns the RAM, selected by the MCU bus-available (BA) line.
- Generates the MCU NMI from an edge-set flip-flop that the MCU clears through port 6.
- Exports the MCU-to-main IRQ and the inverted BA.
- Sits between the main CPU bus decoder and the jt63701 core; contains no CPU.

---
 rtl/jtdd_mcu_pkg.sv | 18 +
 rtl/jtdd_mcu_nmiff.sv | 33 +++
 rtl/jtdd_mcu_comm.sv | 105 ++++++++++
 tb/tb_jtdd_mcu_comm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_mcu_pkg.sv
// jtdd_mcu_pkg
//   Constants shared by the main-CPU / 63701 MCU communication block:
//   shared RAM geometry, the MCU address window used when
//   JTDD_MCU_WINDOW_EN is defined, and the MCU port-6 bit assignments.
package jtdd_mcu_pkg;

  localparam int unsigned SHARED_AW  = 9;
  localparam logic [1:0]  WIN_HI     = 2'b10;  // mcu_AB[15:14] of 0x8000-0xBFFF
  localparam int unsigned P6_NMICLR  = 0;      // low clears the MCU NMI
  localparam int unsigned P6_IRQMAIN = 1;      // drives the main CPU IRQ

  // Shared RAM owner, encoded as the level of the MCU BA line
  typedef enum logic {
    OWN_MCU = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

endpackage

// File: rtl/jtdd_mcu_nmiff.sv
// jtdd_mcu_nmiff
//   Edge-set / level-clear flip-flop that generates the MCU NMI.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset
//     set       : request, sensitive to its rising edge only
//     clr       : level clear, wins over a simultaneous edge
//     q         : flip-flop output
//   The edge detector's history resets to 1, so a request that is already
//   high when reset is released does not count as an edge.
module jtdd_mcu_nmiff (
  input  logic clk,
  input  logic rstn,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
      q    <= 1'b0;
    end else begin
      last <= set;
      if (clr)
        q <= 1'b0;
      else if (set && !last)
        q <= 1'b1;
    end
  end

endmodule

// File: rtl/jtdd_mcu_comm.sv
// jtdd_mcu_comm
//   Glue between the main CPU bus decoder and the jt63701 MCU core.
//   Holds a 2**AW x DW shared RAM owned by either the MCU (mcu_ba=0) or the
//   main CPU (mcu_ba=1), produces the MCU NMI and exports the MCU-to-main
//   IRQ and the inverted BA line.
//   Ports:
//     clk, rstn           : clock, asynchronous active-low reset
//     cen                 : RAM clock enable
//     cpu_AB/wrn/dout     : main CPU address, write strobe (low), data
//     com_cs              : main CPU chip select for the shared RAM
//     mcu_AB/wr/dout      : MCU address, write strobe (high), data
//     mcu_ba              : MCU bus available, low = MCU owns the RAM
//     mcu_p6              : MCU port 6 (bit0 NMI clear, bit1 main IRQ)
//     mcu_nmi_set         : NMI request from the main CPU, rising edge
//     shared_dout         : registered RAM read data for both masters
//     mcu_nmi             : NMI to the MCU
//     mcu_irqmain         : IRQ to the main CPU
//     mcu_ban             : inverted BA
//   Build option: JTDD_MCU_WINDOW_EN restricts MCU writes to 0x8000-0xBFFF.
module jtdd_mcu_comm
  import jtdd_mcu_pkg::*;
#(
  parameter int unsigned AW = SHARED_AW,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic [AW-1:0] cpu_AB,
  input  logic          cpu_wrn,
  input  logic [DW-1:0] cpu_dout,
  input  logic          com_cs,
  input  logic [15:0]   mcu_AB,
  input  logic          mcu_wr,
  input  logic [DW-1:0] mcu_dout,
  input  logic          mcu_ba,
  input  logic [7:0]    mcu_p6,
  input  logic          mcu_nmi_set,
  output logic [DW-1:0] shared_dout,
  output logic          mcu_nmi,
  output logic          mcu_irqmain,
  output logic          mcu_ban
);

  owner_e        owner;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          mcu_we;
  logic          unused_bits;

  logic [DW-1:0] mem [2**AW];

`ifdef JTDD_MCU_WINDOW_EN
  assign mcu_we = mcu_wr & (mcu_AB[15:14] == WIN_HI);
`else
  assign mcu_we = mcu_wr;
`endif

  // Address bits above the RAM and the spare port-6 bits are not decoded
  assign unused_bits = &{1'b0, mcu_AB[15:AW], mcu_p6[7:2]};

  assign owner = owner_e'(mcu_ba);

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (owner == OWN_MCU) begin
      ram_addr = mcu_AB[AW-1:0];
      ram_din  = mcu_dout;
      ram_we   = mcu_we;
    end else begin
      ram_addr = cpu_AB;
      ram_din  = cpu_dout;
      ram_we   = com_cs & ~cpu_wrn;
    end
  end

  // Contents are not reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (cen && ram_we)
      mem[ram_addr] <= ram_din;
  end

  // Read-during-write returns the old contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      shared_dout <= '0;
    else if (cen)
      shared_dout <= mem[ram_addr];
  end

  jtdd_mcu_nmiff u_nmiff (
    .clk  (clk),
    .rstn (rstn),
    .set  (mcu_nmi_set),
    .clr  (~mcu_p6[P6_NMICLR]),
    .q    (mcu_nmi)
  );

  assign mcu_irqmain = mcu_p6[P6_IRQMAIN];
  assign mcu_ban     = ~mcu_ba;

endmodule

// File: tb/tb_jtdd_mcu_comm.sv
module tb_jtdd_mcu_comm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cen;
  logic [8:0]  cpu_AB;
  logic        cpu_wrn;
  logic [7:0]  cpu_dout;
  logic        com_cs;
  logic [15:0] mcu_AB;
  logic        mcu_wr;
  logic [7:0]  mcu_dout;
  logic        mcu_ba;
  logic [7:0]  mcu_p6;
  logic        mcu_nmi_set;
  logic [7:0]  shared_dout;
  logic        mcu_nmi;
  logic        mcu_irqmain;
  logic        mcu_ban;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory image with known flags, read register, NMI
  logic [7:0] m_mem [512];
  bit         m_known [512];
  logic [7:0] m_dout;
  bit         m_dout_known;
  logic       m_nmi;
  logic       m_last;

  jtdd_mcu_comm #(.AW(9), .DW(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cen         (cen),
    .cpu_AB      (cpu_AB),
    .cpu_wrn     (cpu_wrn),
    .cpu_dout    (cpu_dout),
    .com_cs      (com_cs),
    .mcu_AB      (mcu_AB),
    .mcu_wr      (mcu_wr),
    .mcu_dout    (mcu_dout),
    .mcu_ba      (mcu_ba),
    .mcu_p6      (mcu_p6),
    .mcu_nmi_set (mcu_nmi_set),
    .shared_dout (shared_dout),
    .mcu_nmi     (mcu_nmi),
    .mcu_irqmain (mcu_irqmain),
    .mcu_ban     (mcu_ban)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout       = 8'h00;
    m_dout_known = 1'b1;
    m_nmi        = 1'b0;
    m_last       = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven; returns
  // at the next falling edge.
  task automatic tick(input string tag);
    logic [8:0] a;
    logic [7:0] d;
    logic       w;
    logic [7:0] nd;
    bit         nk;
    logic       nn;
    #1;
    chk({tag, ".irqmain"}, {7'd0, mcu_irqmain}, {7'd0, mcu_p6[1]});
    chk({tag, ".ban"}, {7'd0, mcu_ban}, {7'd0, ~mcu_ba});
    if (mcu_ba) begin
      a = cpu_AB;
      d = cpu_dout;
      w = com_cs && !cpu_wrn;
    end else begin
      a = mcu_AB[8:0];
      d = mcu_dout;
`ifdef JTDD_MCU_WINDOW_EN
      w = mcu_wr && (mcu_AB[15:14] == 2'b10);
`else
      w = mcu_wr;
`endif
    end
    nd = m_dout;
    nk = m_dout_known;
    if (cen) begin
      nd = m_mem[a];
      nk = m_known[a];
      if (w) begin
        m_mem[a]   = d;
        m_known[a] = 1'b1;
      end
    end
    if (!mcu_p6[0])                    nn = 1'b0;
    else if (mcu_nmi_set && !m_last)   nn = 1'b1;
    else                               nn = m_nmi;
    @(posedge clk);
    #1;
    m_dout       = nd;
    m_dout_known = nk;
    m_nmi        = nn;
    m_last       = mcu_nmi_set;
    chk({tag, ".nmi"}, {7'd0, mcu_nmi}, {7'd0, m_nmi});
    if (m_dout_known)
      chk({tag, ".dout"}, shared_dout, m_dout);
    @(negedge clk);
  endtask

  task automatic cpu_cycle(input logic [8:0] a, input logic [7:0] d, input logic wr);
    cpu_AB   = a;
    cpu_dout = d;
    com_cs   = 1'b1;
    cpu_wrn  = ~wr;
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 512; i++) m_known[i] = 1'b0;
    rstn = 1'b0; cen = 1'b0; cpu_AB = '0; cpu_wrn = 1'b1; cpu_dout = '0;
    com_cs = 1'b0; mcu_AB = '0; mcu_wr = 1'b0; mcu_dout = '0; mcu_ba = 1'b1;
    mcu_p6 = 8'h01; mcu_nmi_set = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.dout", shared_dout, 8'h00);
    chk("rst.nmi", {7'd0, mcu_nmi}, 8'h00);
    rstn = 1'b1;

    // Fill the whole RAM from the CPU side so later reads are known
    cen = 1'b1;
    for (int i = 0; i < 512; i++) begin
      r = $urandom;
      cpu_cycle(i[8:0], r[7:0], 1'b1);
      tick("fill");
    end

    // CPU write then read back
    cpu_cycle(9'h123, 8'h5A, 1'b1); tick("cpu_wr");
    cpu_cycle(9'h123, 8'h00, 1'b0); tick("cpu_rd");
    chk("cpu_rd.5A", shared_dout, 8'h5A);

    // MCU owns the RAM: CPU writes ignored, MCU writes land
    cpu_cycle(9'h010, 8'h33, 1'b1); tick("pre010");
    mcu_ba = 1'b0; mcu_AB = 16'h8010; mcu_wr = 1'b0;
    cpu_cycle(9'h010, 8'hFF, 1'b1); tick("cpu_blk");
    chk("cpu_blk.ban", {7'd0, mcu_ban}, 8'h01);
    mcu_wr = 1'b0; tick("cpu_blk_rd");
    chk("cpu_blk.33", shared_dout, 8'h33);
    mcu_wr = 1'b1; mcu_dout = 8'hA5; tick("mcu_wr");
    mcu_wr = 1'b0; tick("mcu_rd");
    chk("mcu_rd.A5", shared_dout, 8'hA5);

    // Out-of-window MCU write (dropped only in the window build)
    mcu_AB = 16'h0010; mcu_dout = 8'h77; mcu_wr = 1'b1; tick("win_lo");
    mcu_wr = 1'b0; tick("win_lo_rd");
`ifdef JTDD_MCU_WINDOW_EN
    chk("win_lo.keep", shared_dout, 8'hA5);
`else
    chk("win_lo.hit", shared_dout, 8'h77);
`endif
    mcu_AB = 16'h8010; mcu_dout = 8'h3C; mcu_wr = 1'b1; tick("win_hi");
    mcu_wr = 1'b0; tick("win_hi_rd");
    chk("win_hi.3C", shared_dout, 8'h3C);

    // cen low freezes both RAM and read register
    mcu_ba = 1'b1; cen = 1'b0;
    cpu_cycle(9'h010, 8'hEE, 1'b1); tick("cen0_wr");
    cpu_cycle(9'h055, 8'h00, 1'b0); tick("cen0_rd");
    cen = 1'b1; cpu_cycle(9'h010, 8'h00, 1'b0); tick("cen1_rd");
    chk("cen0.keep", shared_dout, 8'h3C);

    // NMI set, clear, held level does not re-arm
    mcu_p6 = 8'h01; mcu_nmi_set = 1'b1; tick("nmi_set");
    chk("nmi_set.1", {7'd0, mcu_nmi}, 8'h01);
    mcu_p6 = 8'h00; tick("nmi_clr");
    chk("nmi_clr.0", {7'd0, mcu_nmi}, 8'h00);
    mcu_p6 = 8'h01; tick("nmi_hold");
    chk("nmi_hold.0", {7'd0, mcu_nmi}, 8'h00);
    mcu_nmi_set = 1'b0; tick("nmi_lo");

    // Clear wins over a simultaneous edge
    mcu_nmi_set = 1'b1; mcu_p6 = 8'h00; tick("nmi_prio");
    chk("nmi_prio.0", {7'd0, mcu_nmi}, 8'h00);
    mcu_p6 = 8'h01; tick("nmi_prio2");
    mcu_nmi_set = 1'b0; tick("nmi_prio3");

    // IRQ follows port 6 bit 1 combinationally
    mcu_p6 = 8'h03; #1;
    chk("irq.1", {7'd0, mcu_irqmain}, 8'h01);
    @(negedge clk);

    // Asynchronous reset with NMI pending, released with request high
    mcu_nmi_set = 1'b1; tick("pre_rst");
    chk("pre_rst.nmi", {7'd0, mcu_nmi}, 8'h01);
    #2 rstn = 1'b0; #1;
    model_reset();
    chk("arst.nmi", {7'd0, mcu_nmi}, 8'h00);
    chk("arst.dout", shared_dout, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    tick("post_rst");
    chk("post_rst.nmi", {7'd0, mcu_nmi}, 8'h00);
    tick("post_rst2");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cen         = (r[3:0] < 4'd11);
      mcu_ba      = r[4];
      com_cs      = r[5];
      cpu_wrn     = r[6];
      mcu_wr      = r[7];
      mcu_nmi_set = (r[9:8] == 2'b00) ? ~mcu_nmi_set : mcu_nmi_set;
      mcu_p6      = {r[17:12], r[10], (r[15:13] != 3'b000)};
      r = $urandom;
      cpu_AB   = r[8:0];
      cpu_dout = r[16:9];
      mcu_dout = r[24:17];
      r = $urandom;
      mcu_AB   = r[15:0];
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
